mem_write_arbiter: RTL and testbench

Shares the single I2C EEPROM write sequencer between two requesters, for example tag-protocol logging and sensor logging. The block arbitrates round-robin and validates each request against the EEPROM page geometry. It drives the sequencer's run, address, length and device-select inputs, then holds off further access until the EEPROM internal write cycle (tWR) has elapsed. It sits between the requesters and the I2C write sequencer, on the same clock.

---
 rtl/mem_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM write sequencer between two requesters,
// with page-geometry validation and tWR hold-off. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_write_arbiter #(
   parameter int PAGE_BYTES     = 64,
   parameter int WR_CYCLES      = 5000,
   parameter int TIMEOUT_CYCLES = 60000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [14:0] req_addr0,
   input  logic [14:0] req_addr1,
   input  logic [11:0] req_len0,
   input  logic [11:0] req_len1,
   input  logic [2:0]  req_dev0,
   input  logic [2:0]  req_dev1,
   output logic [1:0]  grant,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic        busy,
   output logic        run,
   output logic [14:0] memory_address,
   output logic [11:0] number_of_bytes,
   output logic [2:0]  memory_number,
   input  logic        seq_done,
   input  logic        seq_nack
);

   localparam int WW = $clog2(WR_CYCLES + 1);

   if ((PAGE_BYTES & (PAGE_BYTES - 1)) != 0 || PAGE_BYTES > 4096 || PAGE_BYTES < 1 ||
       WR_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("mem_write_arbiter: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, RUN, WRITE_WAIT, RELEASE} state_e;

   state_e      state_q;
   logic        last_q;
   logic [1:0]  grant_q, done_q, err_q;
   logic        run_q;
   logic [14:0] addr_q;
   logic [11:0] len_q;
   logic [2:0]  dev_q;
   logic [WW-1:0] wcnt_q;
`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] tcnt_q;
`endif

   // Arbitration: a tie goes to whichever requester was not served last.
   logic        win;
   logic [1:0]  win_oh;
   logic [14:0] sel_addr;
   logic [11:0] sel_len;
   logic [2:0]  sel_dev;
   logic [12:0] page_end;
   logic        req_ok;

   always_comb begin
      win = 1'b0;
      if (req == 2'b10)      win = 1'b1;
      else if (req == 2'b11) win = ~last_q;
      win_oh   = win ? 2'b10 : 2'b01;
      sel_addr = win ? req_addr1 : req_addr0;
      sel_len  = win ? req_len1  : req_len0;
      sel_dev  = win ? req_dev1  : req_dev0;
      // 13-bit sum: in-page offset (<4096) plus length (<4096) cannot overflow.
      page_end = 13'(sel_addr & 15'(PAGE_BYTES - 1)) + 13'(sel_len);
      req_ok   = (sel_len != 12'd0) && (page_end <= 13'(PAGE_BYTES));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
         run_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         dev_q   <= '0;
         wcnt_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         tcnt_q  <= '0;
`endif
      end else begin
         done_q <= 2'b00;
         err_q  <= 2'b00;
         case (state_q)
            IDLE: if (|req) begin
               if (!req_ok) begin
                  done_q  <= win_oh;
                  err_q   <= win_oh;
                  state_q <= RELEASE;
               end else begin
                  addr_q  <= sel_addr;
                  len_q   <= sel_len;
                  dev_q   <= sel_dev;
                  grant_q <= win_oh;
                  run_q   <= 1'b1;
                  last_q  <= win;
                  state_q <= RUN;
`ifdef MEM_ARB_TIMEOUT_EN
                  tcnt_q  <= '0;
`endif
               end
            end
            RUN: begin
               if (seq_done) begin
                  run_q <= 1'b0;
                  if (seq_nack) begin
                     done_q  <= grant_q;
                     err_q   <= grant_q;
                     grant_q <= 2'b00;
                     state_q <= RELEASE;
                  end else begin
                     wcnt_q  <= '0;
                     state_q <= WRITE_WAIT;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                  run_q   <= 1'b0;
                  done_q  <= grant_q;
                  err_q   <= grant_q;
                  grant_q <= 2'b00;
                  state_q <= RELEASE;
               end else begin
                  tcnt_q <= tcnt_q + 16'd1;
               end
`endif
            end
            WRITE_WAIT: begin
               if (wcnt_q == WW'(WR_CYCLES - 1)) begin
                  done_q  <= grant_q;
                  grant_q <= 2'b00;
                  state_q <= RELEASE;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant           = grant_q;
   assign done            = done_q;
   assign err             = err_q;
   assign busy            = (state_q != IDLE);
   assign run             = run_q;
   assign memory_address  = addr_q;
   assign number_of_bytes = len_q;
   assign memory_number   = dev_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter: expected done/err pulses are queued when
// stimulus is driven and popped as the DUT pulses; timing and fields checked inline.
module tb_mem_write_arbiter;
   localparam int PB  = 64;
   localparam int WRC = 20;
   localparam int TOC = 100;

   logic        clk = 1'b0, reset = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [14:0] req_addr0 = '0, req_addr1 = '0;
   logic [11:0] req_len0 = '0, req_len1 = '0;
   logic [2:0]  req_dev0 = '0, req_dev1 = '0;
   logic        seq_done = 1'b0, seq_nack = 1'b0;
   logic [1:0]  grant, done, err;
   logic        busy, run;
   logic [14:0] memory_address;
   logic [11:0] number_of_bytes;
   logic [2:0]  memory_number;

   mem_write_arbiter #(.PAGE_BYTES(PB), .WR_CYCLES(WRC), .TIMEOUT_CYCLES(TOC)) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_len0(req_len0), .req_len1(req_len1),
      .req_dev0(req_dev0), .req_dev1(req_dev1),
      .grant(grant), .done(done), .err(err), .busy(busy), .run(run),
      .memory_address(memory_address), .number_of_bytes(number_of_bytes),
      .memory_number(memory_number), .seq_done(seq_done), .seq_nack(seq_nack));

   always #5 clk = ~clk;

   typedef struct { logic [1:0] d; logic [1:0] e; } exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0;

   // Advance one edge, then match any done/err pulse against the queued expectation.
   task automatic cycle();
      exp_t x;
      @(posedge clk); #1;
      if (done !== 2'b00 || err !== 2'b00) begin
         tests++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL sb_unexpected done=%b err=%b", done, err);
         end else begin
            x = sb.pop_front();
            if (done !== x.d || err !== x.e) begin
               fails++; $display("FAIL sb_pulse got done=%b err=%b exp done=%b err=%b", done, err, x.d, x.e);
            end
         end
      end
   endtask

   task automatic set_req(input int i, input logic [14:0] a, input logic [11:0] l, input logic [2:0] d);
      if (i == 0) begin req_addr0 = a; req_len0 = l; req_dev0 = d; end
      else        begin req_addr1 = a; req_len1 = l; req_dev1 = d; end
   endtask

   task automatic nack_pulse(input logic [1:0] who);
      sb.push_back('{who, who});
      seq_done = 1'b1; seq_nack = 1'b1;
      cycle();
      seq_done = 1'b0; seq_nack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      tests++; if ({grant, done, err, run} !== 7'b0) begin fails++; $display("FAIL rst_ctrl got %b exp 0", {grant, done, err, run}); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
      tests++; if ({memory_address, number_of_bytes, memory_number} !== 30'b0) begin
         fails++; $display("FAIL rst_fields got %h exp 0", {memory_address, number_of_bytes, memory_number}); end
      @(posedge clk); #1; reset = 1'b1;
      cycle();
   endtask

   task automatic test_single();
      int k;
      set_req(0, 15'h0040, 12'd16, 3'd3); req = 2'b01;
      sb.push_back('{2'b01, 2'b00});
      cycle();
      tests++; if (grant !== 2'b01 || run !== 1'b1) begin fails++; $display("FAIL single_grant got grant=%b run=%b exp 01/1", grant, run); end
      tests++; if (memory_address !== 15'h0040 || number_of_bytes !== 12'd16 || memory_number !== 3'd3) begin
         fails++; $display("FAIL single_fields got %h/%0d/%0d exp 0040/16/3", memory_address, number_of_bytes, memory_number); end
      repeat (3) cycle();
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL single_run_hold got %b exp 1", run); end
      seq_done = 1'b1; seq_nack = 1'b0;
      cycle();
      seq_done = 1'b0;
      tests++; if (run !== 1'b0 || grant !== 2'b01) begin fails++; $display("FAIL single_wait got run=%b grant=%b exp 0/01", run, grant); end
      k = 0;
      while (done[0] !== 1'b1 && k < WRC + 10) begin cycle(); k++; end
      tests++; if (k !== WRC) begin fails++; $display("FAIL single_twr got %0d cycles exp %0d", k, WRC); end
      req = 2'b00;
      cycle();
      tests++; if (grant !== 2'b00 || busy !== 1'b0 || memory_address !== 15'h0040) begin
         fails++; $display("FAIL single_release got grant=%b busy=%b addr=%h exp 00/0/0040", grant, busy, memory_address); end
      seq_done = 1'b1;
      cycle();
      seq_done = 1'b0;
      tests++; if (busy !== 1'b0 || run !== 1'b0) begin fails++; $display("FAIL stray_seq_done got busy=%b run=%b exp 0/0", busy, run); end
   endtask

   task automatic test_page();
      set_req(0, 15'h003C, 12'd8, 3'd1); req = 2'b01;
      sb.push_back('{2'b01, 2'b01});
      cycle();
      tests++; if (done !== 2'b01 || err !== 2'b01 || run !== 1'b0 || grant !== 2'b00) begin
         fails++; $display("FAIL page_cross got done=%b err=%b run=%b grant=%b exp 01/01/0/00", done, err, run, grant); end
      req = 2'b00; cycle(); cycle();
      set_req(0, 15'h0010, 12'd0, 3'd1); req = 2'b01;
      sb.push_back('{2'b01, 2'b01});
      cycle();
      tests++; if (done !== 2'b01 || err !== 2'b01 || run !== 1'b0) begin
         fails++; $display("FAIL len_zero got done=%b err=%b run=%b exp 01/01/0", done, err, run); end
      req = 2'b00; cycle(); cycle();
      set_req(0, 15'h0038, 12'd8, 3'd2); req = 2'b01;
      cycle();
      tests++; if (run !== 1'b1 || grant !== 2'b01 || memory_address !== 15'h0038) begin
         fails++; $display("FAIL page_edge got run=%b grant=%b addr=%h exp 1/01/0038", run, grant, memory_address); end
      nack_pulse(2'b01);
      req = 2'b00; cycle(); cycle();
   endtask

   task automatic test_nack();
      set_req(1, 15'h7FC0, 12'd64, 3'd5); req = 2'b10;
      cycle();
      tests++; if (grant !== 2'b10 || memory_address !== 15'h7FC0 || number_of_bytes !== 12'd64 || memory_number !== 3'd5) begin
         fails++; $display("FAIL nack_grant got %b/%h/%0d/%0d exp 10/7fc0/64/5", grant, memory_address, number_of_bytes, memory_number); end
      nack_pulse(2'b10);
      tests++; if (done !== 2'b10 || err !== 2'b10 || run !== 1'b0) begin
         fails++; $display("FAIL nack_pulse got done=%b err=%b run=%b exp 10/10/0", done, err, run); end
      req = 2'b00;
      cycle();
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL nack_drop got %b exp 00", grant); end
      repeat (WRC + 3) cycle();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nack_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_tie();
      logic [1:0] exp_g;
      reset = 1'b0; #2;
      set_req(0, 15'h0000, 12'd4, 3'd1);
      set_req(1, 15'h0080, 12'd4, 3'd2);
      req = 2'b11;
      #10; reset = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) begin
         exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
         tests++; if (grant !== exp_g) begin fails++; $display("FAIL tie_grant%0d got %b exp %b", i, grant, exp_g); end
         nack_pulse(exp_g);
         if (i == 2) req = 2'b00;
         cycle();
         tests++; if (grant !== 2'b00) begin fails++; $display("FAIL tie_gap%0d got %b exp 00", i, grant); end
         cycle();
      end
   endtask

   task automatic test_reset_in_wait();
      set_req(0, 15'h0000, 12'd8, 3'd4); req = 2'b01;
      cycle();
      seq_done = 1'b1; seq_nack = 1'b0;
      cycle();
      seq_done = 1'b0;
      repeat (5) cycle();
      tests++; if (grant !== 2'b01 || busy !== 1'b1 || run !== 1'b0) begin
         fails++; $display("FAIL wait_state got grant=%b busy=%b run=%b exp 01/1/0", grant, busy, run); end
      set_req(1, 15'h0100, 12'd4, 3'd6); req = 2'b10;
      #2; reset = 1'b0; #1;
      tests++; if ({grant, done, err, busy, run, memory_address, number_of_bytes, memory_number} !== 38'b0) begin
         fails++; $display("FAIL async_rst got %h exp 0", {grant, done, err, busy, run, memory_address, number_of_bytes, memory_number}); end
      repeat (WRC + 2) cycle();
      tests++; if ({grant, busy, run} !== 4'b0) begin fails++; $display("FAIL rst_hold got %b exp 0", {grant, busy, run}); end
      reset = 1'b1;
      cycle();
      tests++; if (grant !== 2'b10 || run !== 1'b1 || memory_address !== 15'h0100 || memory_number !== 3'd6) begin
         fails++; $display("FAIL post_rst_grant got %b/%b/%h/%0d exp 10/1/0100/6", grant, run, memory_address, memory_number); end
      nack_pulse(2'b10);
      req = 2'b00; cycle(); cycle();
   endtask

   task automatic test_timeout();
      int k;
      set_req(0, 15'h0000, 12'd1, 3'd0); req = 2'b01;
      cycle();
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL to_start got run=%b exp 1", run); end
`ifdef MEM_ARB_TIMEOUT_EN
      sb.push_back('{2'b01, 2'b01});
      k = 0;
      while (run === 1'b1 && k < TOC + 10) begin cycle(); k++; end
      tests++; if (k !== TOC || done !== 2'b01 || err !== 2'b01) begin
         fails++; $display("FAIL timeout got %0d cycles done=%b err=%b exp %0d/01/01", k, done, err, TOC); end
      req = 2'b00; cycle(); cycle();
`else
      k = 0;
      repeat (TOC + 20) cycle();
      tests++; if (run !== 1'b1 || grant !== 2'b01) begin fails++; $display("FAIL no_timeout got run=%b grant=%b exp 1/01", run, grant); end
      nack_pulse(2'b01);
      req = 2'b00; cycle(); cycle();
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_page();
      test_nack();
      test_tie();
      test_reset_in_wait();
      test_timeout();
      repeat (3) cycle();
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover got %0d pending exp 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
